// File: rtl/jtgng_prom_loader.sv
// Routes the ioctl download stream into NPROM contiguous PROMs, counts hits and flags done/short.
// Optional feature: define PROM_LOADER_CHK_EN to add the chk_sum output (mod-2^16 sum of hit bytes).
module jtgng_prom_loader #(
  parameter logic [21:0] PROM_START = 22'h1_8000,
  parameter int          NPROM      = 4,
  parameter int          PROM_AW    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               downloading,
  input  logic [21:0]        ioctl_addr,
  input  logic [7:0]         ioctl_data,
  input  logic               ioctl_wr,
  output logic [PROM_AW-1:0] prom_addr,
  output logic [7:0]         prom_data,
  output logic [NPROM-1:0]   prom_we,
  output logic               busy,
  output logic               done,
  output logic               short_load
`ifdef PROM_LOADER_CHK_EN
  ,
  output logic [15:0]        chk_sum
`endif
);

  localparam int              TOTAL   = NPROM << PROM_AW;
  localparam int              CW      = $clog2(TOTAL + 1);
  localparam int              IW      = (NPROM > 1) ? $clog2(NPROM) : 1;
  localparam logic [21:0]     TOTAL22 = 22'(TOTAL);
  localparam logic [CW-1:0]   TOTAL_C = CW'(TOTAL);

  // FINISH gives the final write (possibly coincident with the fall) time to reach count.
  typedef enum logic [1:0] {IDLE, LOAD, FINISH} state_t;

  state_t         state, state_nxt;
  logic           wr_q;
  logic [CW-1:0]  count;
  logic [21:0]    offset;
  logic [IW-1:0]  index;
  logic           hit, wr_edge, accept;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_nxt = state;
    case (state)
      IDLE:    if (downloading)  state_nxt = LOAD;
      LOAD:    if (!downloading) state_nxt = FINISH;
      FINISH:                    state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase
  end

  // Output / decode logic
  always_comb begin
    offset  = ioctl_addr - PROM_START;
    hit     = (ioctl_addr >= PROM_START) && (offset < TOTAL22);
    index   = IW'(offset >> PROM_AW);
    wr_edge = ioctl_wr & ~wr_q;
    busy    = (state == LOAD);
    accept  = busy && wr_edge && hit;
  end

  // Datapath: strobe, address/data hold, byte count and completion flags
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q       <= 1'b0;
      prom_we    <= '0;
      prom_addr  <= '0;
      prom_data  <= '0;
      count      <= '0;
      done       <= 1'b0;
      short_load <= 1'b0;
`ifdef PROM_LOADER_CHK_EN
      chk_sum    <= '0;
`endif
    end else begin
      // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
      wr_q    <= ioctl_wr;
      prom_we <= '0;
      if (accept) begin
        prom_we[index] <= 1'b1;
        prom_addr      <= offset[PROM_AW-1:0];
        prom_data      <= ioctl_data;
        if (count != TOTAL_C) count <= count + 1'b1;
`ifdef PROM_LOADER_CHK_EN
        chk_sum        <= chk_sum + {8'd0, ioctl_data};
`endif
      end
      case (state)
        IDLE: if (downloading) begin
          done       <= 1'b0;
          short_load <= 1'b0;
          count      <= '0;
`ifdef PROM_LOADER_CHK_EN
          chk_sum    <= '0;
`endif
        end
        FINISH: begin
          done       <= (count == TOTAL_C);
          short_load <= (count != TOTAL_C);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_jtgng_prom_loader.sv
// Scoreboard bench for jtgng_prom_loader: expected strobes queued at drive time, popped on prom_we.
module tb_jtgng_prom_loader;

  typedef struct packed {
    logic [3:0] we;
    logic [7:0] addr;
    logic [7:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        downloading = 1'b0;
  logic [21:0] ioctl_addr = '0;
  logic [7:0]  ioctl_data = '0;
  logic        ioctl_wr = 1'b0;
  logic [7:0]  prom_addr;
  logic [7:0]  prom_data;
  logic [3:0]  prom_we;
  logic        busy, done, short_load;
`ifdef PROM_LOADER_CHK_EN
  logic [15:0] chk_sum;
`endif

  int          checks = 0;
  int          errors = 0;
  int          strobe_cnt = 0;
  bit          in_load = 1'b0;
  logic [15:0] sum_model = '0;
  exp_t        sb[$];

  jtgng_prom_loader dut (
    .clk(clk), .rst(rst), .downloading(downloading),
    .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr),
    .prom_addr(prom_addr), .prom_data(prom_data), .prom_we(prom_we),
    .busy(busy), .done(done), .short_load(short_load)
`ifdef PROM_LOADER_CHK_EN
    , .chk_sum(chk_sum)
`endif
  );

  always #5 clk = ~clk;

  // Strobe monitor: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst && prom_we !== 4'b0) begin
      exp_t e;
      checks++;
      strobe_cnt++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe we=%b addr=%h data=%h", prom_we, prom_addr, prom_data);
      end else begin
        e = sb.pop_front();
        if ({prom_we, prom_addr, prom_data} !== e) begin
          errors++;
          $display("FAIL strobe got we=%b addr=%h data=%h want we=%b addr=%h data=%h",
                   prom_we, prom_addr, prom_data, e.we, e.addr, e.data);
        end
      end
    end
  end

  function automatic void push(input logic [21:0] a, input logic [7:0] d);
    logic [21:0] off;
    exp_t e;
    if (in_load && a >= 22'h18000 && a < 22'h18400) begin
      off    = a - 22'h18000;
      e.we   = 4'b0001 << off[9:8];
      e.addr = off[7:0];
      e.data = d;
      sb.push_back(e);
      sum_model = sum_model + {8'd0, d};
    end
  endfunction

  task automatic wr_byte(input logic [21:0] a, input logic [7:0] d, input int hold);
    @(negedge clk);
    ioctl_addr = a; ioctl_data = d; ioctl_wr = 1'b1;
    push(a, d);
    repeat (hold) @(negedge clk);
    ioctl_wr = 1'b0;
    @(negedge clk);
  endtask

  task automatic start_download();
    @(negedge clk);
    downloading = 1'b1;
    @(negedge clk);
    in_load = 1'b1;
    sum_model = '0;
    checks++;
    if ({busy, done, short_load} !== 3'b100) begin
      errors++;
      $display("FAIL start_flags busy/done/short got %b want 100", {busy, done, short_load});
    end
  endtask

  task automatic finish_check(input logic exp_done, input string name);
    checks++;
    if ({busy, done, short_load} !== {1'b0, exp_done, ~exp_done}) begin
      errors++;
      $display("FAIL %s busy/done/short got %b want %b", name, {busy, done, short_load},
               {1'b0, exp_done, ~exp_done});
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s_missing_strobes got %0d pending want 0", name, sb.size());
    end
`ifdef PROM_LOADER_CHK_EN
    checks++;
    if (chk_sum !== sum_model) begin
      errors++;
      $display("FAIL %s_chk_sum got %h want %h", name, chk_sum, sum_model);
    end
`endif
    sb.delete();
  endtask

  task automatic end_download(input logic exp_done, input string name);
    @(negedge clk);
    downloading = 1'b0;
    in_load = 1'b0;
    repeat (2) @(negedge clk);
    finish_check(exp_done, name);
  endtask

  task automatic expect_cnt(input int got, input int want, input string name);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s strobes got %0d want %0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({prom_we, prom_addr, prom_data, busy, done, short_load} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got we=%b addr=%h data=%h b/d/s=%b want all 0",
               prom_we, prom_addr, prom_data, {busy, done, short_load});
    end
    rst = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if ({prom_we, prom_addr, prom_data, busy, done, short_load} !== '0 || strobe_cnt != 0) begin
      errors++;
      $display("FAIL idle_outputs got we=%b addr=%h data=%h b/d/s=%b strobes=%0d want all 0",
               prom_we, prom_addr, prom_data, {busy, done, short_load}, strobe_cnt);
    end
  endtask

  task automatic test_full();
    int c0 = strobe_cnt;
    start_download();
    for (int i = 0; i < 1024; i++) begin
      wr_byte(22'h18000 + 22'(i), 8'(i), 1);
      if (i == 'h105) begin
        checks++;
        if ({prom_addr, prom_data} !== 16'h0505) begin
          errors++;
          $display("FAIL byte_18105_hold got addr=%h data=%h want 05 05", prom_addr, prom_data);
        end
      end
    end
    checks++;
    if ({prom_addr, prom_data} !== 16'hFFFF) begin
      errors++;
      $display("FAIL window_end_hold got addr=%h data=%h want ff ff", prom_addr, prom_data);
    end
    end_download(1'b1, "full");
    expect_cnt(strobe_cnt - c0, 1024, "full");
  endtask

  task automatic test_held();
    int c0 = strobe_cnt;
    start_download();
    wr_byte(22'h18010, 8'hA5, 5);
    end_download(1'b0, "held");
    expect_cnt(strobe_cnt - c0, 1, "held");
  endtask

  task automatic test_miss();
    int c0 = strobe_cnt;
    start_download();
    wr_byte(22'h17FFF, 8'h11, 1);
    wr_byte(22'h18400, 8'h22, 1);
    wr_byte(22'h3FFFFF, 8'h33, 1);
    expect_cnt(strobe_cnt - c0, 0, "miss");
    for (int i = 0; i < 1000; i++) wr_byte(22'h18000 + 22'(i), 8'(i * 3), 1);
    end_download(1'b0, "short");
    expect_cnt(strobe_cnt - c0, 1000, "short");
  endtask

  task automatic test_reset_mid();
    int c0 = strobe_cnt;
    start_download();
    for (int i = 0; i < 300; i++) wr_byte(22'h18000 + 22'(i), 8'(i), 1);
    // Write edge and reset land on the same clock: the strobe must be dropped.
    @(negedge clk);
    ioctl_addr = 22'h18200; ioctl_data = 8'h77; ioctl_wr = 1'b1;
    rst = 1'b1; downloading = 1'b0; in_load = 1'b0;
    @(negedge clk);
    ioctl_wr = 1'b0;
    @(negedge clk);
    checks++;
    if ({prom_we, prom_addr, prom_data, busy, done, short_load} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs got we=%b addr=%h data=%h b/d/s=%b want all 0",
               prom_we, prom_addr, prom_data, {busy, done, short_load});
    end
    rst = 1'b0;
    expect_cnt(strobe_cnt - c0, 300, "reset_mid");
    test_full();
  endtask

  task automatic test_fall_same_cycle();
    start_download();
    for (int i = 0; i < 1023; i++) wr_byte(22'h18000 + 22'(i), 8'(255 - i), 1);
    @(negedge clk);
    ioctl_addr = 22'h183FF; ioctl_data = 8'h5A; ioctl_wr = 1'b1;
    push(22'h183FF, 8'h5A);
    downloading = 1'b0; in_load = 1'b0;
    @(negedge clk);
    ioctl_wr = 1'b0;
    @(negedge clk);
    finish_check(1'b1, "fall_same_cycle");
  endtask

`ifdef PROM_LOADER_CHK_EN
  task automatic test_chk();
    start_download();
    for (int i = 0; i < 1024; i++) wr_byte(22'h18000 + 22'(i), 8'hFF, 1);
    end_download(1'b1, "chk_full");
    checks++;
    if (chk_sum !== 16'hFC00) begin
      errors++;
      $display("FAIL chk_sum_ff got %h want fc00", chk_sum);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_full();
    test_held();
    test_miss();
    test_reset_mid();
    test_fall_same_cycle();
`ifdef PROM_LOADER_CHK_EN
    test_chk();
`endif
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
